pipeline_issue_ctrl: RTL

Single-clock issue controller for the four-stage register/memory pipeline. Buffers incoming instruction words (func, ra1, ra2, rwa, ma) in a small FIFO and issues at most one per cycle to the pipeline's operand/control inputs. Stalls on read-after-write hazards against regbank writes still in flight. Sits between the instruction source and the pipeline; the pipeline itself has no stall input, so all hazard resolution lives here.

---
 rtl/pipeline_pkg.sv | 44 ++++
 rtl/issue_fifo.sv | 47 ++++
 rtl/pipeline_issue_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline issue controller: instruction layout and FSM states.
package pipeline_pkg;

  localparam int INSTR_W = 24;
  localparam int REG_W   = 4;

  localparam int FUNC_LSB = 20;
  localparam int FUNC_W   = 4;
  localparam int RA1_LSB  = 16;
  localparam int RA1_W    = REG_W;
  localparam int RA2_LSB  = 12;
  localparam int RA2_W    = REG_W;
  localparam int RWA_LSB  = 8;
  localparam int RWA_W    = REG_W;
  localparam int MA_LSB   = 0;
  localparam int MA_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } issue_state_e;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [RA1_W-1:0]  ra1;
    logic [RA2_W-1:0]  ra2;
    logic [RWA_W-1:0]  rwa;
    logic [MA_W-1:0]   ma;
  } instr_t;

  // Split a raw instruction word into its named fields.
  function automatic instr_t instr_unpack(input logic [INSTR_W-1:0] word);
    instr_t f;
    f.func = word[FUNC_LSB +: FUNC_W];
    f.ra1  = word[RA1_LSB  +: RA1_W];
    f.ra2  = word[RA2_LSB  +: RA2_W];
    f.rwa  = word[RWA_LSB  +: RWA_W];
    f.ma   = word[MA_LSB   +: MA_W];
    return f;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous instruction buffer; head word is visible combinationally on rdata.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the buffer without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issue controller: buffers instructions and issues one per cycle, stalling on
// read-after-write hazards against regbank writes still in flight.
//
//   state | meaning
//   IDLE  | FIFO empty, scoreboard clear
//   RUN   | head issuable (or writes still retiring)
//   STALL | head blocked by an in-flight write
//   DRAIN | drain held, finishing queued work
module pipeline_issue_ctrl
  import pipeline_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WB_LAT     = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               drain,
  output logic               iss_valid,
  output logic [FUNC_W-1:0]  iss_func,
  output logic [REG_W-1:0]   iss_ra1,
  output logic [REG_W-1:0]   iss_ra2,
  output logic [REG_W-1:0]   iss_rwa,
  output logic [MA_W-1:0]    iss_ma,
  output logic               idle,
  output logic [CNT_W-1:0]   issue_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic               full;
  logic               empty;
  logic               push;
  logic               issue;
  logic               blocked;
  logic               hazard;
  logic               sb_busy;
  logic [INSTR_W-1:0] head_raw;
  instr_t             head;
  logic [WB_LAT-1:0]  sb_v;
  logic [REG_W-1:0]   sb_rwa [WB_LAT];
  issue_state_e       state;

  assign in_ready = !full && !drain;
  assign push     = in_valid && in_ready;
  assign head     = instr_unpack(head_raw);

  issue_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (issue),
    .wdata (in_instr),
    .rdata (head_raw),
    .full  (full),
    .empty (empty)
  );

  // Hazard compare. The oldest entry is the write landing this cycle, which a
  // stage-1 read already sees, so it never blocks the head.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_LAT - 1; i++) begin
      if (sb_v[i] && ((sb_rwa[i] == head.ra1) || (sb_rwa[i] == head.ra2))) hazard = 1'b1;
    end
  end

  assign blocked = !empty && hazard;
  assign issue   = !empty && !hazard;
  assign sb_busy = |sb_v;
  assign idle    = empty && !sb_busy;

  // Write-in-flight scoreboard: one slot per cycle of writeback latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_v <= '0;
      for (int i = 0; i < WB_LAT; i++) sb_rwa[i] <= '0;
    end else begin
      sb_v      <= {sb_v[WB_LAT-2:0], issue};
      sb_rwa[0] <= head.rwa;
      for (int i = 1; i < WB_LAT; i++) sb_rwa[i] <= sb_rwa[i-1];
    end
  end

  // Issue registers and performance counters; fields hold between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_func  <= '0;
      iss_ra1   <= '0;
      iss_ra2   <= '0;
      iss_rwa   <= '0;
      iss_ma    <= '0;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      iss_valid <= issue;
      if (issue) begin
        iss_func  <= head.func;
        iss_ra1   <= head.ra1;
        iss_ra2   <= head.ra2;
        iss_rwa   <= head.rwa;
        iss_ma    <= head.ma;
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (blocked) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Controller state tracking the buffer, scoreboard and drain request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (drain && !idle) state <= DRAIN;
          else if (push)      state <= RUN;
        end
        RUN, STALL: begin
          if (drain)                       state <= DRAIN;
          else if (idle && !push)          state <= IDLE;
          else if (blocked)                state <= STALL;
          else                             state <= RUN;
        end
        DRAIN: begin
          if (!drain)   state <= (idle && !push) ? IDLE : RUN;
          else if (idle) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
